// File: rtl/div_unit_if.sv
// div_unit_if: EX-stage to divider handshake bundle
// Signals:
//   signed_div_i  1 = DIV (signed), 0 = DIVU
//   opdata1_i     dividend, captured at start
//   opdata2_i     divisor, captured at start
//   start_i       request, held by EX until the result is consumed
//   annul_i       abort the operation in flight
//   result_o      {remainder, quotient}, valid while ready_o = 1
//   ready_o       result valid
// Modports: master = EX side, slave = divider side.
interface div_unit_if;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;
    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o
    );
    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o
    );
endinterface

// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring 32-bit divider for MIPS DIV/DIVU
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  div_unit_if.slave: operands/start/annul in, {remainder, quotient}/ready out
// Configuration macro DIV_SIGNED_EN: when defined, signed_div_i selects signed
// division with operand conditioning and result sign correction; when undefined
// every operation is unsigned and that logic is absent. Timing is identical.
// Latency: start sampled at E0, 32 steps on E1..E32, result and ready on E33.
// Divide by zero: result 0, ready after E2.
module div_unit (
    input  logic      clk,
    input  logic      rst,
    div_unit_if.slave bus
);
    typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;
    state_t      state;
    logic [5:0]  cnt;
    logic [64:0] work;
    logic [31:0] divisor;
    logic [64:0] shifted;
    logic [33:0] diff;
    logic [31:0] dividend_in;
    logic [31:0] divisor_in;
    logic [31:0] quot;
    logic [31:0] rem;
    logic        accept;
    assign accept  = (state == FREE) && bus.start_i && !bus.annul_i;
    assign shifted = {work[63:0], 1'b0};
    // Trial subtraction; bit 33 set means the difference went negative (restore).
    assign diff    = {1'b0, shifted[64:32]} - {2'b00, divisor};
`ifdef DIV_SIGNED_EN
    logic neg1;
    logic neg2;
    logic sign1;
    logic sign2;
    assign neg1        = bus.signed_div_i & bus.opdata1_i[31];
    assign neg2        = bus.signed_div_i & bus.opdata2_i[31];
    assign dividend_in = neg1 ? -bus.opdata1_i : bus.opdata1_i;
    assign divisor_in  = neg2 ? -bus.opdata2_i : bus.opdata2_i;
    // Quotient negative when signs differ; remainder follows the dividend.
    assign quot        = (sign1 ^ sign2) ? -work[31:0] : work[31:0];
    assign rem         = sign1 ? -work[63:32] : work[63:32];
    always_ff @(posedge clk) begin
        if (rst) begin
            sign1 <= 1'b0;
            sign2 <= 1'b0;
        end else if (accept) begin
            sign1 <= neg1;
            sign2 <= neg2;
        end
    end
`else
    assign dividend_in = bus.opdata1_i;
    assign divisor_in  = bus.opdata2_i;
    assign quot        = work[31:0];
    assign rem         = work[63:32];
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= FREE;
            cnt          <= 6'd0;
            work         <= 65'd0;
            divisor      <= 32'd0;
            bus.ready_o  <= 1'b0;
            bus.result_o <= 64'd0;
        end else begin
            case (state)
                FREE: begin
                    bus.ready_o  <= 1'b0;
                    bus.result_o <= 64'd0;
                    if (accept) begin
                        if (bus.opdata2_i == 32'd0) begin
                            state <= BYZERO;
                        end else begin
                            state   <= ON;
                            cnt     <= 6'd0;
                            work    <= {33'd0, dividend_in};
                            divisor <= divisor_in;
                        end
                    end
                end
                BYZERO: state <= bus.annul_i ? FREE : END;
                ON: begin
                    if (bus.annul_i) begin
                        state <= FREE;
                    end else if (cnt == 6'd32) begin
                        bus.result_o <= {rem, quot};
                        bus.ready_o  <= 1'b1;
                        state        <= END;
                    end else begin
                        work <= diff[33] ? shifted : {diff[32:0], shifted[31:1], 1'b1};
                        cnt  <= cnt + 6'd1;
                    end
                end
                END: begin
                    // Entered from BYZERO with ready low and result zero;
                    // ready rises here on the following edge.
                    if (!bus.start_i) begin
                        state        <= FREE;
                        bus.ready_o  <= 1'b0;
                        bus.result_o <= 64'd0;
                    end else begin
                        bus.ready_o <= 1'b1;
                    end
                end
                default: state <= FREE;
            endcase
        end
    end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: scoreboard bench for div_unit with directed vectors
module tb_div_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    div_unit_if bus();
    div_unit dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    int total = 0;
    int bad = 0;
    logic [63:0] exp_q[$];
    task automatic check(input string nm, input logic [64:0] act, input logic [64:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask
    initial begin
        logic prev;
        logic [63:0] e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.ready_o && !prev) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_ready", {1'b0, bus.result_o}, 65'h1_0000_0000_0000_0000);
                end else begin
                    e = exp_q.pop_front();
                    check("result", {1'b0, bus.result_o}, {1'b0, e});
                end
            end
            prev = bus.ready_o;
        end
    end
    task automatic run_op(input string nm, input logic sg, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] req, input int req_lat);
        int lat;
        @(negedge clk);
        bus.signed_div_i = sg;
        bus.opdata1_i    = a;
        bus.opdata2_i    = b;
        bus.start_i      = 1'b1;
        exp_q.push_back(req);
        @(posedge clk);
        @(negedge clk);
        bus.opdata1_i    = ~a;
        bus.opdata2_i    = b ^ 32'h5;
        bus.signed_div_i = ~sg;
        lat = 0;
        while (lat < 60) begin
            @(posedge clk);
            lat++;
            #1;
            if (bus.ready_o) break;
        end
        check({nm, "_lat"}, 65'(lat), 65'(req_lat));
        repeat (3) @(posedge clk);
        #1;
        check({nm, "_hold"}, {bus.ready_o, bus.result_o}, {1'b1, req});
        @(negedge clk);
        bus.start_i = 1'b0;
        @(posedge clk);
        #1;
        check({nm, "_drop"}, {bus.ready_o, bus.result_o}, 65'd0);
    endtask
    task automatic expect_idle(input string nm, input int n);
        logic seen;
        seen = 1'b0;
        repeat (n) begin
            @(negedge clk);
            if (bus.ready_o) seen = 1'b1;
        end
        check(nm, {64'd0, seen}, 65'd0);
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
    initial begin
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = 32'd0;
        bus.opdata2_i    = 32'd0;
        bus.start_i      = 1'b0;
        bus.annul_i      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset", {bus.ready_o, bus.result_o}, 65'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op("divu_100_7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33);
        run_op("divu_7_100", 1'b0, 32'd7, 32'd100, {32'd7, 32'd0}, 33);
        run_op("divu_max_1", 1'b0, 32'hFFFFFFFF, 32'd1, {32'd0, 32'hFFFFFFFF}, 33);
        run_op("divu_max_10000", 1'b0, 32'hFFFFFFFF, 32'h10000, {32'h0000FFFF, 32'h0000FFFF}, 33);
        run_op("div_pos_pos", 1'b1, 32'd100, 32'd7, {32'd2, 32'd14}, 33);
`ifdef DIV_SIGNED_EN
        run_op("div_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 33);
        run_op("div_min_m1", 1'b1, 32'h80000000, 32'hFFFFFFFF, {32'h00000000, 32'h80000000}, 33);
        run_op("div_m100_m7", 1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, {32'hFFFFFFFE, 32'h0000000E}, 33);
        run_op("div_100_m7", 1'b1, 32'd100, 32'hFFFFFFF9, {32'd2, 32'hFFFFFFF2}, 33);
`else
        run_op("div_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, {32'd1, 32'h7FFFFFFC}, 33);
        run_op("div_min_m1", 1'b1, 32'h80000000, 32'hFFFFFFFF, {32'h80000000, 32'h00000000}, 33);
        run_op("div_m100_m7", 1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, {32'hFFFFFF9C, 32'h00000000}, 33);
        run_op("div_100_m7", 1'b1, 32'd100, 32'hFFFFFFF9, {32'd100, 32'd0}, 33);
`endif
        run_op("divu_5_0", 1'b0, 32'd5, 32'd0, 64'd0, 2);
        // divide by zero annulled at E1
        @(negedge clk);
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = 32'd5;
        bus.opdata2_i    = 32'd0;
        bus.start_i      = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.annul_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.annul_i = 1'b0;
        bus.start_i = 1'b0;
        expect_idle("byzero_annul", 10);
        // annul at E10 of a running divide
        @(negedge clk);
        bus.opdata1_i = 32'd100;
        bus.opdata2_i = 32'd7;
        bus.start_i   = 1'b1;
        @(posedge clk);
        repeat (9) @(posedge clk);
        @(negedge clk);
        bus.annul_i = 1'b1;
        @(posedge clk);
        #1;
        check("annul_e10", {bus.ready_o, bus.result_o}, 65'd0);
        @(negedge clk);
        bus.annul_i = 1'b0;
        bus.start_i = 1'b0;
        expect_idle("annul_idle", 40);
        run_op("after_annul", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33);
        // reset at E20 of a running divide
        @(negedge clk);
        bus.opdata1_i = 32'd1000;
        bus.opdata2_i = 32'd3;
        bus.start_i   = 1'b1;
        @(posedge clk);
        repeat (19) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("reset_e20", {bus.ready_o, bus.result_o}, 65'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.start_i = 1'b0;
        expect_idle("reset_idle", 40);
        // reset coincident with start
        @(negedge clk);
        rst = 1'b1;
        bus.opdata1_i = 32'd9;
        bus.opdata2_i = 32'd3;
        bus.start_i   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        bus.start_i = 1'b0;
        expect_idle("reset_start_idle", 40);
        run_op("after_reset", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33);
        repeat (2) @(posedge clk);
        check("queue_empty", 65'(exp_q.size()), 65'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
